controlador_display_mux: RTL and testbench

CONTROLADOR_DISPLAY_MUX -- requirements
Module: controlador_display_mux

---
 rtl/controlador_display_mux.sv | 108 ++++++++++
 tb/tb_controlador_display_mux.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/controlador_display_mux.sv
// Four-digit multiplexed 7-seg scan with frame-synchronous double-buffered load; outputs registered (change with the state).
// Load handshake: o_Listo low while a load waits for frame end; optional macro BLANK_CEROS_EN adds leading-zero blanking.
module controlador_display_mux #(
  parameter int P_DIV = 50000
) (
  input  logic        i_Clk,
  input  logic        i_Reset,
  input  logic [15:0] i_Dato,
  input  logic        i_Cargar,
  output logic        o_Listo,
  input  logic        i_Habilitar,
  output logic [3:0]  o_Nibble,
  output logic [3:0]  o_Anodo,
  output logic        o_Fin_Cuadro
);

  localparam int CW = (P_DIV > 1) ? $clog2(P_DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(P_DIV - 1);

  typedef enum logic [1:0] {DIG0, DIG1, DIG2, DIG3} state_t;

  state_t      state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [15:0] disp, disp_nxt;
  logic [15:0] shadow, shadow_nxt;
  logic        pending, pending_nxt;
  logic [3:0]  nibble_nxt, anodo_nxt;
  logic        tick, frame_end, accept;
`ifdef BLANK_CEROS_EN
  logic        blank_nxt;
`endif

  always_comb begin
    tick        = (cnt == CNT_MAX);
    frame_end   = tick && (state == DIG3);
    accept      = i_Cargar && !pending;
    state_nxt   = state;
    cnt_nxt     = cnt + 1'b1;
    disp_nxt    = disp;
    shadow_nxt  = shadow;
    pending_nxt = pending;

    if (tick) begin
      cnt_nxt = '0;
      case (state)
        DIG0:    state_nxt = DIG1;
        DIG1:    state_nxt = DIG2;
        DIG2:    state_nxt = DIG3;
        default: state_nxt = DIG0;
      endcase
    end

    // Frame-end copy uses the pending flag from before this edge, so a load
    // accepted on the frame-end edge waits for the next frame.
    if (frame_end && pending) begin
      disp_nxt    = shadow;
      pending_nxt = 1'b0;
    end
    if (accept) begin
      shadow_nxt  = i_Dato;
      pending_nxt = 1'b1;
    end

    case (state_nxt)
      DIG0:    nibble_nxt = disp_nxt[3:0];
      DIG1:    nibble_nxt = disp_nxt[7:4];
      DIG2:    nibble_nxt = disp_nxt[11:8];
      default: nibble_nxt = disp_nxt[15:12];
    endcase

    anodo_nxt = 4'b1111;
    if (i_Habilitar) anodo_nxt = ~(4'b0001 << state_nxt);
`ifdef BLANK_CEROS_EN
    case (state_nxt)
      DIG0:    blank_nxt = 1'b0;
      DIG1:    blank_nxt = (disp_nxt[15:4] == 12'h000);
      DIG2:    blank_nxt = (disp_nxt[15:8] == 8'h00);
      default: blank_nxt = (disp_nxt[15:12] == 4'h0);
    endcase
    if (blank_nxt) anodo_nxt = 4'b1111;
`endif
  end

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      state        <= DIG0;
      cnt          <= '0;
      disp         <= '0;
      shadow       <= '0;
      pending      <= 1'b0;
      o_Nibble     <= 4'h0;
      o_Anodo      <= 4'b1111;
      o_Fin_Cuadro <= 1'b0;
    end else begin
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      disp         <= disp_nxt;
      shadow       <= shadow_nxt;
      pending      <= pending_nxt;
      o_Nibble     <= nibble_nxt;
      o_Anodo      <= anodo_nxt;
      o_Fin_Cuadro <= frame_end;
    end
  end

  assign o_Listo = !pending;

endmodule

// File: tb/tb_controlador_display_mux.sv
// Directed + random bench; reference model tracks position within the frame as a plain integer.
module tb_controlador_display_mux;
  localparam int P     = 4;
  localparam int FRAME = 4 * P;

  logic        clk = 1'b0;
  logic        reset, cargar, hab;
  logic [15:0] dato;
  logic        listo, fin;
  logic [3:0]  nibble, anodo;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model state
  int          pos;
  logic [15:0] m_disp, m_shadow;
  bit          m_pend;
  logic [3:0]  e_nib, e_an;
  logic        e_fin;

  controlador_display_mux #(.P_DIV(P)) dut (
    .i_Clk(clk), .i_Reset(reset), .i_Dato(dato), .i_Cargar(cargar),
    .o_Listo(listo), .i_Habilitar(hab), .o_Nibble(nibble),
    .o_Anodo(anodo), .o_Fin_Cuadro(fin)
  );

  always #5 clk = ~clk;

  function automatic bit blanked(input int d, input logic [15:0] v);
`ifdef BLANK_CEROS_EN
    return (d >= 1) && ((v >> (4 * d)) == 16'h0000);
`else
    return 1'b0;
`endif
  endfunction

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h (pos=%0d)", tag, obs, exp, pos);
    end
  endtask

  task automatic tick();
    int d;
    bit fe, acc;
    @(posedge clk);
    if (reset) begin
      pos = 0; m_disp = 16'h0; m_shadow = 16'h0; m_pend = 0;
      e_nib = 4'h0; e_an = 4'hF; e_fin = 1'b0;
    end else begin
      fe  = (pos == FRAME - 1);
      acc = cargar && !m_pend;
      if (fe && m_pend) begin
        m_disp = m_shadow;
        m_pend = 0;
      end
      if (acc) begin
        m_shadow = dato;
        m_pend   = 1;
      end
      pos   = (pos + 1) % FRAME;
      d     = pos / P;
      e_nib = m_disp[4*d +: 4];
      e_an  = 4'hF;
      if (hab && !blanked(d, m_disp)) e_an[d] = 1'b0;
      e_fin = fe;
    end
    #1;
    check("nibble", {12'h0, nibble}, {12'h0, e_nib});
    check("anodo",  {12'h0, anodo},  {12'h0, e_an});
    check("listo",  {15'h0, listo},  {15'h0, !m_pend});
    check("fin",    {15'h0, fin},    {15'h0, e_fin});
  endtask

  task automatic wait_ready();
    for (int i = 0; i < 64 && m_pend; i++) tick();
    if (m_pend) begin
      n_checks++; n_fail++;
      $error("FAIL wait_ready observed=busy expected=ready");
    end
  endtask

  task automatic load(input logic [15:0] v);
    wait_ready();
    cargar = 1'b1; dato = v;
    tick();
    cargar = 1'b0;
  endtask

  initial begin
    reset = 1'b1; cargar = 1'b0; dato = 16'h0; hab = 1'b1;
    repeat (2) tick();
    reset = 1'b0;

    // load right after reset, then a second load that must be ignored
    cargar = 1'b1; dato = 16'h1234;
    tick();
    cargar = 1'b0;
    tick();
    cargar = 1'b1; dato = 16'hABCD;
    tick();
    cargar = 1'b0;
    repeat (40) tick();

    // disable: anodes off, frame pulses keep their period
    hab = 1'b0;
    repeat (20) tick();
    hab = 1'b1;

    // load presented exactly on the frame-end edge
    for (int i = 0; i < 64 && !(pos == FRAME - 1 && !m_pend); i++) tick();
    if (!(pos == FRAME - 1 && !m_pend)) begin
      n_checks++; n_fail++;
      $error("FAIL wait_frame_end observed=pos%0d expected=pos%0d", pos, FRAME - 1);
    end
    cargar = 1'b1; dato = 16'h5A5A;
    tick();
    cargar = 1'b0;
    repeat (40) tick();

    // leading-zero patterns
    load(16'h0050);
    repeat (36) tick();
    load(16'h0000);
    repeat (36) tick();
    load(16'h0700);
    repeat (36) tick();

    // reset in the middle of DIG2 with a load pending
    load(16'h9876);
    for (int i = 0; i < 64 && !((pos / P) == 2 && m_pend); i++) tick();
    if (!((pos / P) == 2 && m_pend)) begin
      n_checks++; n_fail++;
      $error("FAIL wait_dig2 observed=pos%0d expected=digit2_pending", pos);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    repeat (20) tick();

    // random traffic
    for (int i = 0; i < 600; i++) begin
      cargar = ($urandom % 4 == 0);
      dato   = 16'($urandom);
      hab    = ($urandom % 8 != 0);
      reset  = ($urandom % 150 == 0);
      tick();
    end
    reset = 1'b0; cargar = 1'b0;
    repeat (4) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
